opsel_decode_seq: RTL and testbench
===================================

OPSEL_DECODE_SEQ -- requirements
Module: opsel_decode_seq

Interface
REQ-001 Parameter: SRAM_TIMEOUT, default 16, maximum cycles spent in SRAM_WAIT before abort (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready.
REQ-006 cmd_reg  input  4  target state-memory register index 0..15.
REQ-007 cmd_opsel  input  4  encoded operation select.
REQ-008 sram_done  input  1  SRAM access complete (sampled only in SRAM_WAIT).
REQ-009 err_clr  input  1  clears both sticky error flags.
REQ-010 en0..en15  output  8 each  registered per-register enable vectors: bits 0-5 = op enables 0-5, bit 7 = op enable 6, bit 6 = sram_en.
REQ-011 busy  output  1  high while in SRAM_WAIT.
REQ-012 err_illegal  output  1  sticky: illegal opsel accepted.
REQ-013 err_timeout  output  1  sticky: SRAM access aborted by timeout.

Function
REQ-014 OpSel decode: 0 = NOP (no bits); 1..6 = bits 0..5; 7 = bit 7; 8 = bit 6 (SRAM op); 9..15 = illegal.
REQ-015 States: IDLE, SRAM_WAIT; cmd_ready = 1 in IDLE, 0 in SRAM_WAIT (combinational from state only, independent of cmd_valid).
REQ-016 In IDLE, accepted non-SRAM op: cycle after acceptance, en<cmd_reg> = decoded one-hot, all other en vectors 0, for exactly one cycle; state stays IDLE.
REQ-017 Back-to-back non-SRAM commands sustain one per cycle; each produces its own one-cycle pulse with 1-cycle latency.
REQ-018 Cycle with no acceptance in IDLE: all en vectors 0 next cycle.
REQ-019 Accepted NOP: no enable asserted, no error.
REQ-020 Accepted illegal opsel (9..15): no enable asserted, err_illegal set next cycle, state stays IDLE.
REQ-021 Accepted SRAM op (8): next cycle enter SRAM_WAIT, bit 6 of en<cmd_reg> asserted and held, all other bits/vectors 0; captured register index held internally.
REQ-022 In SRAM_WAIT, 8-bit cycle counter starts at 0 on entry and increments each cycle.
REQ-023 sram_done high in SRAM_WAIT: next cycle sram_en deasserted, state IDLE, cmd_ready high.
REQ-024 Counter reaching SRAM_TIMEOUT-1 with sram_done low: next cycle sram_en deasserted, state IDLE, err_timeout set.
REQ-025 sram_done and timeout in same cycle: done wins, err_timeout not set.
REQ-026 sram_done in IDLE: ignored.
REQ-027 cmd_valid in SRAM_WAIT: not accepted; command inputs must be held by source until accepted.
REQ-028 Errors: err_clr clears flags next cycle; simultaneous set and err_clr: set wins.
REQ-029 At most one en vector nonzero and at most one bit set in it, in every cycle.

Reset
REQ-030 n_rst low asynchronously forces: state IDLE, counter 0, all en vectors 0, busy 0, err_illegal 0, err_timeout 0; cmd_ready 1 immediately after reset release.
REQ-031 Reset asserted during SRAM_WAIT immediately drops sram_en; pending access discarded, no error flagged.

Verification
REQ-032 Reset release, cmd_reg=3, cmd_opsel=7, one cycle -> next cycle en3=8'h80, all others 0; following cycle all 0.
REQ-033 Back-to-back opsel 1,2,3 to regs 0,5,15 -> en0=8'h01, en5=8'h02, en15=8'h04 on consecutive cycles, cmd_ready constant 1.
REQ-034 cmd_reg=9, opsel=8, sram_done pulsed 4 cycles after entry -> en9=8'h40 held 5 cycles, busy 1 for same interval, cmd_ready 0, then IDLE, no errors.
REQ-035 SRAM op to reg 2, sram_done never asserted, SRAM_TIMEOUT=16 -> en2=8'h40 exactly 16 cycles, then 0, err_timeout=1; err_clr pulse -> 0 next cycle.
REQ-036 opsel=12 to reg 1 -> all en 0, err_illegal=1 next cycle; opsel=12 with err_clr same cycle -> err_illegal stays 1.
REQ-037 n_rst asserted mid-SRAM_WAIT (reg 7) -> en7 0 and busy 0 without clock edge; err_timeout 0 after release.

Source files
------------

// File: rtl/opsel_decode_seq_if.sv
// Command channel for opsel_decode_seq.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
// The source keeps cmd_valid, cmd_reg and cmd_opsel stable until that edge.
// The sink drives cmd_ready from its state only, never from cmd_valid.
interface opsel_decode_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_reg;
  logic [3:0] cmd_opsel;

  modport master (
    output cmd_valid,
    output cmd_reg,
    output cmd_opsel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_reg,
    input  cmd_opsel,
    output cmd_ready
  );
endinterface

// File: rtl/opsel_decode_seq.sv
// Decodes an operation select into per-register one-hot enable pulses.
// The SRAM op (opsel 8) holds its enable in SRAM_WAIT until sram_done or a timeout.
module opsel_decode_seq #(
  parameter int SRAM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  opsel_decode_seq_if.slave   cmd,
  input  logic                sram_done,
  input  logic                err_clr,
  output logic [7:0]          en0,
  output logic [7:0]          en1,
  output logic [7:0]          en2,
  output logic [7:0]          en3,
  output logic [7:0]          en4,
  output logic [7:0]          en5,
  output logic [7:0]          en6,
  output logic [7:0]          en7,
  output logic [7:0]          en8,
  output logic [7:0]          en9,
  output logic [7:0]          en10,
  output logic [7:0]          en11,
  output logic [7:0]          en12,
  output logic [7:0]          en13,
  output logic [7:0]          en14,
  output logic [7:0]          en15,
  output logic                busy,
  output logic                err_illegal,
  output logic                err_timeout,
  output logic                dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Last counter value allowed in SRAM_WAIT before aborting.
  localparam logic [7:0] TMO_LAST = 8'(SRAM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        reg_q, reg_d;
  logic [15:0][7:0]  en_q, en_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_timeout_q, err_timeout_d;
  logic              accept;

  // Enable bit for each opsel; opsel 8 maps to the sram_en bit (bit 6).
  function automatic logic [7:0] decode_op(input logic [3:0] op);
    logic [7:0] v;
    case (op)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h40;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign accept = (state_q == ST_IDLE) && cmd.cmd_valid;

  // Next-state, enable and sticky-error computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reg_d         = reg_q;
    en_d          = '0;
    // A set in the same cycle overrides the clear below.
    err_illegal_d = err_illegal_q & ~err_clr;
    err_timeout_d = err_timeout_q & ~err_clr;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.cmd_opsel >= 4'd9) begin
            err_illegal_d = 1'b1;
          end else if (cmd.cmd_opsel == 4'd8) begin
            state_d            = ST_WAIT;
            reg_d              = cmd.cmd_reg;
            cnt_d              = 8'd0;
            en_d[cmd.cmd_reg]  = 8'h40;
          end else begin
            en_d[cmd.cmd_reg]  = decode_op(cmd.cmd_opsel);
          end
        end
      end
      ST_WAIT: begin
        // Completion has priority over the timeout in the same cycle.
        if (sram_done) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == TMO_LAST) begin
          state_d       = ST_IDLE;
          cnt_d         = 8'd0;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + 8'd1;
          en_d[reg_q]  = 8'h40;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, counter, captured register index, enables and error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      reg_q         <= 4'd0;
      en_q          <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reg_q         <= reg_d;
      en_q          <= en_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_WAIT);
  assign dbg_state     = (state_q == ST_WAIT);
  assign err_illegal   = err_illegal_q;
  assign err_timeout   = err_timeout_q;

  assign en0  = en_q[0];
  assign en1  = en_q[1];
  assign en2  = en_q[2];
  assign en3  = en_q[3];
  assign en4  = en_q[4];
  assign en5  = en_q[5];
  assign en6  = en_q[6];
  assign en7  = en_q[7];
  assign en8  = en_q[8];
  assign en9  = en_q[9];
  assign en10 = en_q[10];
  assign en11 = en_q[11];
  assign en12 = en_q[12];
  assign en13 = en_q[13];
  assign en14 = en_q[14];
  assign en15 = en_q[15];

endmodule

// File: tb/tb_opsel_decode_seq.sv
// Bench for opsel_decode_seq: transaction-level model feeding an expected
// queue, a per-cycle compare process, and directed scenarios with literal checks.
module tb_opsel_decode_seq;

  localparam int TMO = 16;
  localparam int W   = 132;

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;
  logic sram_done;
  logic err_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] en0, en1, en2, en3, en4, en5, en6, en7;
  logic [7:0] en8, en9, en10, en11, en12, en13, en14, en15;
  logic       busy, err_illegal, err_timeout, dbg_state;

  opsel_decode_seq_if cmd_if ();

  opsel_decode_seq #(.SRAM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .cmd         (cmd_if),
    .sram_done   (sram_done),
    .err_clr     (err_clr),
    .en0         (en0),
    .en1         (en1),
    .en2         (en2),
    .en3         (en3),
    .en4         (en4),
    .en5         (en5),
    .en6         (en6),
    .en7         (en7),
    .en8         (en8),
    .en9         (en9),
    .en10        (en10),
    .en11        (en11),
    .en12        (en12),
    .en13        (en13),
    .en14        (en14),
    .en15        (en15),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  logic [7:0] en_arr [16];
  assign en_arr[0]  = en0;
  assign en_arr[1]  = en1;
  assign en_arr[2]  = en2;
  assign en_arr[3]  = en3;
  assign en_arr[4]  = en4;
  assign en_arr[5]  = en5;
  assign en_arr[6]  = en6;
  assign en_arr[7]  = en7;
  assign en_arr[8]  = en8;
  assign en_arr[9]  = en9;
  assign en_arr[10] = en10;
  assign en_arr[11] = en11;
  assign en_arr[12] = en12;
  assign en_arr[13] = en13;
  assign en_arr[14] = en14;
  assign en_arr[15] = en15;

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [127:0] en_pack();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = en_arr[i];
    return v;
  endfunction

  function automatic logic [127:0] one_en(input int r, input logic [7:0] val);
    logic [127:0] v;
    v = '0;
    v[r*8 +: 8] = val;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_en(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // Transaction view: an idle unit accepts any presented command; an SRAM op
  // keeps the unit waiting for at most TMO cycles counted from entry.
  logic [W-1:0] exp_q [$];
  logic         m_wait;
  int           m_reg;
  int           m_elapsed;
  logic         m_ill;
  logic         m_tmo;
  logic [7:0]   m_en [16];
  logic         m_ill_set;
  logic         m_tmo_set;
  int           m_op;
  int           m_r;
  logic [W-1:0] m_vec;

  initial begin
    m_wait = 1'b0; m_reg = 0; m_elapsed = 0; m_ill = 1'b0; m_tmo = 1'b0;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_wait    = 1'b0;
      m_reg     = 0;
      m_elapsed = 0;
      m_ill     = 1'b0;
      m_tmo     = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < 16; i++) m_en[i] = 8'h00;
      m_ill_set = 1'b0;
      m_tmo_set = 1'b0;
      if (!m_wait) begin
        if (cmd_if.cmd_valid) begin
          m_op = int'(cmd_if.cmd_opsel);
          m_r  = int'(cmd_if.cmd_reg);
          if (m_op >= 1 && m_op <= 6)  m_en[m_r] = 8'(1 << (m_op - 1));
          else if (m_op == 7)          m_en[m_r] = 8'h80;
          else if (m_op == 8) begin
            m_wait    = 1'b1;
            m_reg     = m_r;
            m_elapsed = 1;
            m_en[m_r] = 8'h40;
          end else if (m_op >= 9)      m_ill_set = 1'b1;
        end
      end else begin
        if (sram_done) m_wait = 1'b0;
        else if (m_elapsed == TMO) begin
          m_wait    = 1'b0;
          m_tmo_set = 1'b1;
        end else begin
          m_elapsed++;
          m_en[m_reg] = 8'h40;
        end
      end
      m_ill = m_ill_set | (m_ill & ~err_clr);
      m_tmo = m_tmo_set | (m_tmo & ~err_clr);
      m_vec[131] = ~m_wait;
      m_vec[130] = m_wait;
      m_vec[129] = m_ill;
      m_vec[128] = m_tmo;
      for (int i = 0; i < 16; i++) m_vec[i*8 +: 8] = m_en[i];
      exp_q.push_back(m_vec);
    end
  end

  // Per-cycle compare of every output against the model, plus the
  // at-most-one-enable-bit property.
  always @(negedge clk) begin
    logic [W-1:0] ev;
    logic [127:0] act_en;
    int           ones;
    if (n_rst && exp_q.size() > 0) begin
      ev     = exp_q.pop_front();
      act_en = en_pack();
      check_en("cyc_en", act_en, ev[127:0]);
      check("cyc_ready", {31'd0, cmd_if.cmd_ready}, {31'd0, ev[131]});
      check("cyc_busy", {31'd0, busy}, {31'd0, ev[130]});
      check("cyc_err_illegal", {31'd0, err_illegal}, {31'd0, ev[129]});
      check("cyc_err_timeout", {31'd0, err_timeout}, {31'd0, ev[128]});
      ones = $countones(act_en);
      check("cyc_onehot", {31'd0, (ones > 1)}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic [3:0] r, input logic [3:0] op);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_reg   = r;
    cmd_if.cmd_opsel = op;
  endtask

  task automatic idle_cmd();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_reg   = 4'd0;
    cmd_if.cmd_opsel = 4'd0;
  endtask

  // Called at the first negedge inside SRAM_WAIT. Counts cycles with busy
  // high; raises sram_done during the done_at-th such cycle (0 = never).
  task automatic wait_sram(input int r, input int done_at, output int held);
    held = 0;
    while (busy === 1'b1 && held < 300) begin
      held++;
      check_en("sram_en_held", en_pack(), one_en(r, 8'h40));
      check("sram_ready_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
      if (held == done_at) sram_done = 1'b1;
      tick();
      sram_done = 1'b0;
    end
    if (held >= 300) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sram_wait_bound: still busy after %0d cycles, required exit", held);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [7:0] dec_tbl [16];
  int         held;

  initial begin
    dec_tbl = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h80,
                8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_rst     = 1'b0;
    sram_done = 1'b0;
    err_clr   = 1'b0;
    idle_cmd();
    repeat (2) tick();

    // Reset state
    check_en("rst_en", en_pack(), '0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    #2 n_rst = 1'b1;
    tick();

    // Single op 7 to reg 3: one-cycle 0x80 pulse
    drive_cmd(4'd3, 4'd7);
    tick();
    idle_cmd();
    check_en("op7_reg3", en_pack(), one_en(3, 8'h80));
    tick();
    check_en("op7_reg3_after", en_pack(), '0);

    // Back-to-back ops 1,2,3 to regs 0,5,15
    drive_cmd(4'd0, 4'd1);
    tick();
    check_en("b2b_0", en_pack(), one_en(0, 8'h01));
    check("b2b_ready0", {31'd0, cmd_if.cmd_ready}, 32'd1);
    drive_cmd(4'd5, 4'd2);
    tick();
    check_en("b2b_1", en_pack(), one_en(5, 8'h02));
    check("b2b_ready1", {31'd0, cmd_if.cmd_ready}, 32'd1);
    drive_cmd(4'd15, 4'd3);
    tick();
    idle_cmd();
    check_en("b2b_2", en_pack(), one_en(15, 8'h04));
    tick();

    // NOP and sram_done while idle
    drive_cmd(4'd4, 4'd0);
    sram_done = 1'b1;
    tick();
    idle_cmd();
    sram_done = 1'b0;
    check_en("nop_en", en_pack(), '0);
    check("nop_err", {30'd0, err_illegal, err_timeout}, 32'd0);
    check("idle_done_busy", {31'd0, busy}, 32'd0);

    // SRAM op to reg 9, done during the 5th wait cycle
    drive_cmd(4'd9, 4'd8);
    tick();
    idle_cmd();
    wait_sram(9, 5, held);
    check("sram_done_held", held, 32'd5);
    check("sram_done_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("sram_done_err", {30'd0, err_illegal, err_timeout}, 32'd0);
    check_en("sram_done_en", en_pack(), '0);

    // SRAM op to reg 2, never done: timeout after TMO cycles
    drive_cmd(4'd2, 4'd8);
    tick();
    idle_cmd();
    wait_sram(2, 0, held);
    check("tmo_held", held, TMO);
    check("tmo_flag", {31'd0, err_timeout}, 32'd1);
    check_en("tmo_en", en_pack(), '0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_clr", {31'd0, err_timeout}, 32'd0);

    // Done and timeout in the same cycle: done wins
    drive_cmd(4'd4, 4'd8);
    tick();
    idle_cmd();
    wait_sram(4, TMO, held);
    check("tie_held", held, TMO);
    check("tie_no_tmo", {31'd0, err_timeout}, 32'd0);

    // Command held during SRAM_WAIT is taken once idle again
    drive_cmd(4'd6, 4'd8);
    tick();
    drive_cmd(4'd11, 4'd5);
    wait_sram(6, 2, held);
    check("held_cmd_wait", held, 32'd2);
    tick();
    idle_cmd();
    check_en("held_cmd_en", en_pack(), one_en(11, 8'h10));

    // Illegal opsel, clear, and set-vs-clear collision
    drive_cmd(4'd1, 4'd12);
    tick();
    idle_cmd();
    check_en("ill_en", en_pack(), '0);
    check("ill_flag", {31'd0, err_illegal}, 32'd1);
    check("ill_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill_clr", {31'd0, err_illegal}, 32'd0);
    drive_cmd(4'd1, 4'd12);
    err_clr = 1'b1;
    tick();
    idle_cmd();
    err_clr = 1'b0;
    check("ill_set_wins", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Opsel sweep (SRAM op excluded), register index follows opsel
    for (int op = 0; op < 16; op++) begin
      if (op != 8) begin
        drive_cmd(4'(op), 4'(op));
        tick();
        check_en("sweep_en", en_pack(), one_en(op, dec_tbl[op]));
        check("sweep_ill", {31'd0, err_illegal}, {31'd0, (op >= 9)});
      end
    end
    idle_cmd();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Asynchronous reset in the middle of SRAM_WAIT
    drive_cmd(4'd7, 4'd8);
    tick();
    idle_cmd();
    tick();
    tick();
    check_en("arst_pre_en", en_pack(), one_en(7, 8'h40));
    #2 n_rst = 1'b0;
    #1;
    check_en("arst_en", en_pack(), '0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    tick();
    tick();
    #2 n_rst = 1'b1;
    tick();
    check("arst_tmo", {31'd0, err_timeout}, 32'd0);
    check("arst_busy_after", {31'd0, busy}, 32'd0);
    repeat (TMO + 2) tick();
    check("arst_tmo_late", {31'd0, err_timeout}, 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
